// File: rtl/sdram_access_arbiter.sv
// rtl/sdram_access_arbiter.sv - round-robin host arbiter sharing the SDRAM command path with refresh
// Optional grant watchdog enabled by defining SDRAM_ARB_WATCHDOG_EN.
module sdram_access_arbiter #(
  parameter int N_REQ    = 2,
  parameter int T_RFC    = 8,
  parameter int BW_RFC   = 4,
  parameter int MAX_HOLD = 64,
  parameter int BW_HOLD  = 7
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             status_i,
  input  logic             refresh_i,
  output logic             refresh_exec_o,
  output logic             refresh_busy_o,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] release_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             timeout_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 1 || N_REQ > 8 || T_RFC < 1 || (2 ** BW_RFC) <= T_RFC ||
      MAX_HOLD < 1 || (2 ** BW_HOLD) <= MAX_HOLD) begin : g_param_check
    $error("sdram_access_arbiter: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, REFRESH, GRANT} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     idx_next;
  logic              found;
  logic [BW_RFC-1:0] rfc_cnt;
  int                rr_j;

  // First requesting host at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    rr_j  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_j = int'(ptr) + i;
      if (rr_j >= N_REQ) rr_j = rr_j - N_REQ;
      if (!found && req_i[PW'(rr_j)]) begin
        found = 1'b1;
        sel   = PW'(rr_j);
      end
    end
  end

  assign idx_next = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;

`ifdef SDRAM_ARB_WATCHDOG_EN
  logic [BW_HOLD-1:0] hold_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      ptr            <= '0;
      idx            <= '0;
      rfc_cnt        <= '0;
      grant_o        <= '0;
      refresh_exec_o <= 1'b0;
      refresh_busy_o <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      hold_cnt       <= '0;
      timeout_o      <= 1'b0;
`endif
    end else if (!status_i) begin
      state          <= IDLE;
      grant_o        <= '0;
      refresh_exec_o <= 1'b0;
      refresh_busy_o <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      timeout_o      <= 1'b0;
`endif
    end else begin
      refresh_exec_o <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      timeout_o      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (refresh_i) begin
            state          <= REFRESH;
            refresh_exec_o <= 1'b1;
            refresh_busy_o <= 1'b1;
            rfc_cnt        <= BW_RFC'(T_RFC - 1);
          end else if (found) begin
            state   <= GRANT;
            idx     <= sel;
            grant_o <= N_REQ'(1) << sel;
`ifdef SDRAM_ARB_WATCHDOG_EN
            hold_cnt <= BW_HOLD'(MAX_HOLD - 1);
`endif
          end
        end
        REFRESH: begin
          if (rfc_cnt == '0) begin
            state          <= IDLE;
            refresh_busy_o <= 1'b0;
          end else begin
            rfc_cnt <= rfc_cnt - 1'b1;
          end
        end
        GRANT: begin
          if (release_i[idx]) begin
            state   <= IDLE;
            grant_o <= '0;
            ptr     <= idx_next;
`ifdef SDRAM_ARB_WATCHDOG_EN
          end else if (hold_cnt == '0) begin
            state     <= IDLE;
            grant_o   <= '0;
            timeout_o <= 1'b1;
            ptr       <= idx_next;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb/tb_sdram_access_arbiter.sv - directed self-checking bench for sdram_access_arbiter
module tb_sdram_access_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       status;
  logic       refresh;
  logic       refresh_exec;
  logic       refresh_busy;
  logic [1:0] req;
  logic [1:0] release_s;
  logic [1:0] grant;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  sdram_access_arbiter #(
    .N_REQ(2), .T_RFC(8), .BW_RFC(4), .MAX_HOLD(16), .BW_HOLD(5)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .status_i(status),
    .refresh_i(refresh),
    .refresh_exec_o(refresh_exec),
    .refresh_busy_o(refresh_busy),
    .req_i(req),
    .release_i(release_s),
    .grant_o(grant),
    .timeout_o(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {exec, busy, grant, timeout} for compact whole-output checks.
  function automatic logic [7:0] outs();
    return {3'b000, refresh_exec, refresh_busy, grant, timeout};
  endfunction

  initial begin
    reset = 1'b1; status = 1'b0; refresh = 1'b0; req = 2'b00; release_s = 2'b00;
    repeat (3) tick();
    chk("reset_outputs", outs(), 8'h00);

    // Init gating: requests and refresh ignored while uninitialized.
    reset = 1'b0; req = 2'b11; refresh = 1'b1;
    for (int i = 0; i < 20; i++) chk("init_gate", outs(), 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("init_gate_cycle", outs(), 8'h00);
    end

    status = 1'b1;
    tick();
    chk("init_exec", outs(), 8'b0001_1000);
    refresh = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("init_busy", outs(), 8'b0000_1000);
    end
    tick();
    chk("init_busy_end", outs(), 8'h00);

    // Round robin with req=11 held, each grant released after 3 cycles.
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant_c1", {6'd0, grant}, {6'd0, exp_g});
      release_s = ~exp_g;
      tick();
      release_s = 2'b00;
      chk("rr_foreign_release", {6'd0, grant}, {6'd0, exp_g});
      tick();
      chk("rr_grant_c3", outs(), {5'd0, exp_g, 1'b0});
      release_s = exp_g;
      if (k == 3) req = 2'b00;
      tick();
      release_s = 2'b00;
      chk("rr_idle_gap", outs(), 8'h00);
      tick();
    end
    chk("rr_no_req", outs(), 8'h00);

    // Refresh raised during a grant is taken right after release.
    req = 2'b11;
    tick();
    chk("rg_grant0", {6'd0, grant}, 8'h01);
    tick();
    refresh = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rg_no_preempt", outs(), 8'b0000_0010);
    end
    release_s = 2'b01;
    tick();
    release_s = 2'b00;
    chk("rg_release_idle", outs(), 8'h00);
    tick();
    chk("rg_exec", outs(), 8'b0001_1000);
    refresh = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("rg_busy", outs(), 8'b0000_1000);
    end
    tick();
    chk("rg_busy_end", outs(), 8'h00);
    tick();
    chk("rg_host1_next", {6'd0, grant}, 8'h02);
    release_s = 2'b10; req = 2'b00;
    tick();
    release_s = 2'b00;
    chk("rg_host1_release", outs(), 8'h00);

    // Accumulated refreshes: two windows, one idle cycle apart, then host0.
    refresh = 1'b1; req = 2'b01;
    tick();
    chk("acc_exec1", outs(), 8'b0001_1000);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("acc_busy1", outs(), 8'b0000_1000);
    end
    tick();
    chk("acc_gap", outs(), 8'h00);
    tick();
    chk("acc_exec2", outs(), 8'b0001_1000);
    refresh = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("acc_busy2", outs(), 8'b0000_1000);
    end
    tick();
    chk("acc_busy2_end", outs(), 8'h00);
    tick();
    chk("acc_grant0", outs(), 8'b0000_0010);
    release_s = 2'b01; req = 2'b00;
    tick();
    release_s = 2'b00;
    chk("acc_release", outs(), 8'h00);

    // Reset on busy cycle 4 aborts the refresh and clears the pointer (was 1).
    refresh = 1'b1;
    tick();
    chk("rst_exec", outs(), 8'b0001_1000);
    refresh = 1'b0;
    repeat (3) tick();
    chk("rst_busy4", outs(), 8'b0000_1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_abort", outs(), 8'h00);
    req = 2'b11;
    tick();
    chk("rst_ptr0", {6'd0, grant}, 8'h01);
    release_s = 2'b01;
    tick();
    release_s = 2'b00;
    chk("rst_release", outs(), 8'h00);

    // Host1 granted and never releases.
    tick();
    chk("wd_grant1", outs(), 8'b0000_0100);
`ifdef SDRAM_ARB_WATCHDOG_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd_hold", outs(), 8'b0000_0100);
    end
    tick();
    chk("wd_revoke", outs(), 8'b0000_0001);
    tick();
    chk("wd_host0_next", outs(), 8'b0000_0010);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nowd_hold", outs(), 8'b0000_0100);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
